// File: rtl/reset_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer_if
// Description : Bundles the soft-reset request and the sequencer status and
//               reset outputs.
//               soft_rst_req : synchronous soft-reset request, active-high
//               rst_n_out    : per-domain active-low resets, bit 0 first
//               seq_done     : all domains released
//               busy         : a release sequence is in progress
//               master : the requester / consumer side (top level, bench)
//               slave  : the reset_sequencer itself
// Revision    : 1.0 - initial release
// ============================================================================
interface reset_sequencer_if #(
    parameter int NUM_DOMAINS = 3
);
    logic                   soft_rst_req;
    logic [NUM_DOMAINS-1:0] rst_n_out;
    logic                   seq_done;
    logic                   busy;

    modport master (
        output soft_rst_req,
        input  rst_n_out,
        input  seq_done,
        input  busy
    );

    modport slave (
        input  soft_rst_req,
        output rst_n_out,
        output seq_done,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Power-on / soft reset sequencer. Stretches the asynchronous
//               active-low RST_N, synchronises its release to CLK, holds
//               domain 0 for HOLD_CYCLES and then releases the remaining
//               domains one every STAGGER_CYCLES. A soft-reset request
//               accepted while idle re-runs the hold/stagger sequence.
// Ports       : CLK   - single clock
//               RST_N - asynchronous active-low reset
//               bus   - reset_sequencer_if.slave (soft_rst_req in;
//                       rst_n_out, seq_done, busy out; all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
    parameter int NUM_DOMAINS    = 3,   // 1..8
    parameter int HOLD_CYCLES    = 16,  // >= 1
    parameter int STAGGER_CYCLES = 4,   // >= 1
    parameter int SYNC_STAGES    = 2    // 2..4
) (
    input  wire logic          CLK,
    input  wire logic          RST_N,
    reset_sequencer_if.slave   bus
);

    localparam int MAX_CNT = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = CNT_W'(MAX_CNT);
    localparam logic [IDX_W-1:0] c_LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_STAGGER = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_idx_nxt;
    logic [IDX_W-1:0]       w_idx_inc;
    logic [NUM_DOMAINS-1:0] r_rst_n_out;
    logic [NUM_DOMAINS-1:0] w_rst_n_nxt;
    logic [NUM_DOMAINS-1:0] w_rst_n_shift;
    logic                   r_seq_done;
    logic                   w_seq_done_nxt;
    logic                   r_busy;
    logic                   w_busy_nxt;
    logic                   w_sync_done;

    // Release synchroniser: ones shift in after RST_N rises, cleared at once
    // when RST_N falls.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_sync_done = r_sync[SYNC_STAGES-1];

    // Counter saturates rather than wrapping.
    assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    assign w_idx_inc = r_idx + 1'b1;

    // Domains release in order, so the next release pattern is the current
    // pattern shifted up with a 1 entering at bit 0.
    assign w_rst_n_shift = (r_rst_n_out << 1) | NUM_DOMAINS'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_idx_nxt      = r_idx;
        w_rst_n_nxt    = r_rst_n_out;
        w_seq_done_nxt = 1'b0;
        w_busy_nxt     = 1'b1;

        case (r_state)
            // The edge that sees the synchroniser full is the first hold
            // cycle, so SYNC and HOLD share the hold-count test (r_cnt is
            // still 0 in SYNC).
            ST_SYNC, ST_HOLD: begin
                if (r_state == ST_HOLD || w_sync_done) begin
                    if (r_cnt == c_HOLD_LAST) begin
                        w_rst_n_nxt = w_rst_n_shift;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = '0;
                        w_state_nxt = (NUM_DOMAINS == 1) ? ST_DONE : ST_STAGGER;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                        w_state_nxt = ST_HOLD;
                    end
                end
            end

            ST_STAGGER: begin
                if (r_cnt == c_STAG_LAST) begin
                    w_rst_n_nxt = w_rst_n_shift;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = w_idx_inc;
                    if (w_idx_inc == c_LAST_IDX) begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            ST_DONE: begin
                w_seq_done_nxt = 1'b1;
                w_busy_nxt     = 1'b0;
                // Only accepted once seq_done is visible, so a held request
                // still yields a one-cycle seq_done pulse every period.
                if (r_seq_done && bus.soft_rst_req) begin
                    w_rst_n_nxt    = '0;
                    w_seq_done_nxt = 1'b0;
                    w_busy_nxt     = 1'b1;
                    w_cnt_nxt      = '0;
                    w_idx_nxt      = '0;
                    w_state_nxt    = ST_HOLD;
                end
            end

            default: begin
                w_state_nxt = ST_SYNC;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= ST_SYNC;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_rst_n_out <= '0;
            r_seq_done  <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_rst_n_out <= w_rst_n_nxt;
            r_seq_done  <= w_seq_done_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign bus.rst_n_out = r_rst_n_out;
    assign bus.seq_done  = r_seq_done;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Drives three reset_sequencer configurations from one clock
//               and one RST_N, with random soft-reset requests and random
//               RST_N pulses. Expected outputs come from a release-time
//               model: each domain k releases at base + offset + k*S.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    localparam int N0 = 3, H0 = 16, S0 = 4, Y0 = 2;
    localparam int N1 = 4, H1 = 5,  S1 = 2, Y1 = 3;
    localparam int N2 = 1, H2 = 1,  S2 = 1, Y2 = 2;

    int p_n [3] = '{N0, N1, N2};
    int p_h [3] = '{H0, H1, H2};
    int p_s [3] = '{S0, S1, S2};
    int p_y [3] = '{Y0, Y1, Y2};

    logic clk;
    logic rst_n;
    logic req [3];

    int   n_vec;
    int   n_err;
    int   e;            // edges since RST_N release
    int   base [3];
    int   off  [3];
    logic prev_done [3];
    int   mode;

    reset_sequencer_if #(.NUM_DOMAINS(N0)) bus0 ();
    reset_sequencer_if #(.NUM_DOMAINS(N1)) bus1 ();
    reset_sequencer_if #(.NUM_DOMAINS(N2)) bus2 ();

    reset_sequencer #(.NUM_DOMAINS(N0), .HOLD_CYCLES(H0), .STAGGER_CYCLES(S0), .SYNC_STAGES(Y0))
        u_dut0 (.CLK(clk), .RST_N(rst_n), .bus(bus0));
    reset_sequencer #(.NUM_DOMAINS(N1), .HOLD_CYCLES(H1), .STAGGER_CYCLES(S1), .SYNC_STAGES(Y1))
        u_dut1 (.CLK(clk), .RST_N(rst_n), .bus(bus1));
    reset_sequencer #(.NUM_DOMAINS(N2), .HOLD_CYCLES(H2), .STAGGER_CYCLES(S2), .SYNC_STAGES(Y2))
        u_dut2 (.CLK(clk), .RST_N(rst_n), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: edge %0d got %h expected %h", tag, e, obs, exp);
        end
    endtask

    // Packed as {pad, rst_n_out (8), seq_done, busy}.
    function automatic logic [15:0] obs_vec(int i);
        case (i)
            0:       return {6'b0, 5'b0, bus0.rst_n_out, bus0.seq_done, bus0.busy};
            1:       return {6'b0, 4'b0, bus1.rst_n_out, bus1.seq_done, bus1.busy};
            default: return {6'b0, 7'b0, bus2.rst_n_out, bus2.seq_done, bus2.busy};
        endcase
    endfunction

    function automatic logic [15:0] exp_vec(int i);
        logic [7:0] b;
        logic       d;
        b = '0;
        for (int k = 0; k < p_n[i]; k++) begin
            b[k] = (e >= base[i] + off[i] + k * p_s[i]);
        end
        d = (e >= base[i] + off[i] + (p_n[i] - 1) * p_s[i] + 1);
        return {6'b0, b, d, ~d};
    endfunction

    task automatic model_reset();
        e = 0;
        for (int i = 0; i < 3; i++) begin
            base[i]      = 0;
            off[i]       = p_y[i] + p_h[i];
            prev_done[i] = 1'b0;
        end
    endtask

    // One rising edge: a request is taken only if seq_done was already high.
    task automatic model_step();
        e++;
        for (int i = 0; i < 3; i++) begin
            if (prev_done[i] && req[i]) begin
                base[i] = e;
                off[i]  = p_h[i];
            end
        end
        for (int i = 0; i < 3; i++) begin
            logic [15:0] v;
            v            = exp_vec(i);
            prev_done[i] = v[1];
        end
    endtask

    task automatic drive_req();
        bus0.soft_rst_req = req[0];
        bus1.soft_rst_req = req[1];
        bus2.soft_rst_req = req[2];
    endtask

    task automatic check_all(input string tag);
        check_vec({tag, "_d0"}, obs_vec(0), exp_vec(0));
        check_vec({tag, "_d1"}, obs_vec(1), exp_vec(1));
        check_vec({tag, "_d2"}, obs_vec(2), exp_vec(2));
    endtask

    task automatic rst_pulse();
        int len;
        len   = $urandom_range(1, 4);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("arst");
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            check_all("inrst");
        end
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        mode  = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) req[i] = 1'b0;
        drive_req();
        model_reset();

        repeat (2) @(negedge clk);
        check_all("por");
        rst_n = 1'b1;

        // Power-on with no soft requests, plus fixed release points.
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_all("pwr");
            if (e == 17) check_vec("d0_e17", {13'b0, bus0.rst_n_out}, 16'h0000);
            if (e == 18) check_vec("d0_e18", {13'b0, bus0.rst_n_out}, 16'h0001);
            if (e == 22) check_vec("d0_e22", {13'b0, bus0.rst_n_out}, 16'h0003);
            if (e == 26) check_vec("d0_e26", {13'b0, bus0.rst_n_out, bus0.seq_done}, 16'h000E);
            if (e == 27) check_vec("d0_e27", {14'b0, bus0.seq_done, bus0.busy}, 16'h0002);
            if (e == 2)  check_vec("d2_e2",  {15'b0, bus2.rst_n_out}, 16'h0000);
            if (e == 3)  check_vec("d2_e3",  {14'b0, bus2.rst_n_out, bus2.seq_done}, 16'h0002);
            if (e == 4)  check_vec("d2_e4",  {15'b0, bus2.seq_done}, 16'h0001);
        end

        // Random soft requests and RST_N pulses.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) == 0) mode = $urandom_range(0, 2);
            if ($urandom_range(0, 249) == 0) begin
                rst_pulse();
            end else begin
                for (int i = 0; i < 3; i++) begin
                    case (mode)
                        0:       req[i] = ($urandom_range(0, 29) == 0);
                        1:       req[i] = $urandom_range(0, 1) == 1;
                        default: req[i] = 1'b1;
                    endcase
                end
                drive_req();
                @(posedge clk);
                model_step();
                @(negedge clk);
                check_all("run");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised power-on and soft reset sequencer for iCE40 UP5K designs. It sits between the on-chip oscillator/reset source and the BSV top-level and design sub-blocks. It stretches an asynchronous active-low reset, synchronises its release to `CLK`, and releases `NUM_DOMAINS` reset outputs in a fixed staggered order. A synchronous soft-reset request re-runs the same sequence without a power cycle.

## Interface
Parameters:
- `NUM_DOMAINS`, 3: number of reset outputs; legal range 1..8.
- `HOLD_CYCLES`, 16: cycles domain 0 is held in reset after the synchronised release; must be ≥1.
- `STAGGER_CYCLES`, 4: cycles between successive domain releases; must be ≥1.
- `SYNC_STAGES`, 2: reset-release synchroniser depth; legal range 2..4.

Ports:
- `CLK`  in  1  single clock (48 MHz HFOSC in current designs).
- `RST_N`  in  1  reset, asynchronous, active-low.
- `soft_rst_req`  in  1  synchronous soft-reset request, active-high.
- `rst_n_out`  out  NUM_DOMAINS  per-domain active-low resets; bit 0 is released first.
- `seq_done`  out  1  high once all domains are released.
- `busy`  out  1  high while a sequence is in progress (HOLD or STAGGER state).

## Operation
- The internal counter is wide enough for max(HOLD_CYCLES, STAGGER_CYCLES); it saturates and never wraps.
- Domain index width is clog2(NUM_DOMAINS), minimum 1 bit.
- States:
  - SYNC: waiting for the synchroniser to fill with 1s.
  - HOLD: counting HOLD_CYCLES.
  - STAGGER: releasing domains 1..N-1.
  - DONE: all domains released.
- RST_N low, asynchronously and immediately:
  - `rst_n_out`=0 (all bits), `seq_done`=0, `busy`=1.
  - Synchroniser cleared, counter=0, domain index=0, state=SYNC.
- SYNC → HOLD when the last synchroniser stage reads 1.
- HOLD: counter increments each cycle. When it reaches HOLD_CYCLES:
  - `rst_n_out[0]`←1, counter←0.
  - NUM_DOMAINS=1: next state is DONE.
  - Otherwise: next state is STAGGER.
- STAGGER: counter increments each cycle. When it reaches STAGGER_CYCLES:
  - The next domain bit is set; the counter clears.
  - After the last bit is set, state → DONE.
- DONE:
  - `seq_done`=1, `busy`=0.
  - `soft_rst_req` is sampled every cycle here and only here.
  - If it is high: all `rst_n_out`←0, `seq_done`←0, `busy`←1, counter←0, state→HOLD. The synchroniser is bypassed because the request is already synchronous.
- `soft_rst_req` in SYNC/HOLD/STAGGER is ignored: no restart and no queueing.
- `soft_rst_req` held high continuously re-triggers each time DONE is reached.
- Once released, a domain bit stays 1 until RST_N goes low or a soft reset is accepted. Bits are never released out of order.

## Timing
- Edge numbering: edge 1 is the first rising `CLK` edge with RST_N high.
- Synchroniser output is high after edge SYNC_STAGES.
- Power-on release, with B = SYNC_STAGES + HOLD_CYCLES:
  - `rst_n_out[k]` rises after edge B + k·STAGGER_CYCLES.
  - `seq_done` rises and `busy` falls one edge after the last domain bit rises.
- Defaults (N=3, H=16, S=4, SYNC=2):
  - `rst_n_out[0]` after edge 18, `[1]` after edge 22, `[2]` after edge 26.
  - `seq_done` after edge 27.
- Soft reset accepted at edge R (DONE, request high):
  - All outputs are low after edge R.
  - `rst_n_out[k]` rises after edge R + HOLD_CYCLES + k·STAGGER_CYCLES.
  - `seq_done` rises one edge after the last release.
- RST_N assertion mid-sequence, or during soft-reset hold, aborts immediately. The full sequence, including SYNC, restarts on the next deassertion.
- RST_N deasserted within setup/hold of `CLK`: the synchroniser absorbs it. Release timing may slip by one edge and no more.
- All outputs are registered. No combinational path from RST_N deassertion or `soft_rst_req` to any output.

## Test plan
- Power-on, defaults: deassert RST_N → `rst_n_out` reads 001 after edge 18, 011 after 22, 111 after 26; `seq_done`=1 and `busy`=0 after 27.
- RST_N pulsed low for 3 cycles after edge 20 → all outputs 0 asynchronously within the same cycle. After re-release, the timings above repeat relative to the new edge 1.
- Soft reset: one-cycle `soft_rst_req` at edge R in DONE → outputs 000 after R; 001 at R+16, 011 at R+20, 111 at R+24; `seq_done` at R+25.
- `soft_rst_req` pulsed during HOLD and STAGGER → no change to power-on timing; `seq_done` still rises after edge 27.
- Params N=1, H=1, S=1, SYNC=2 → `rst_n_out[0]` after edge 3, `seq_done` after edge 4.
- `soft_rst_req` held high → the sequence repeats back-to-back with period H + (N−1)·S + 2 cycles (defaults: 26); `seq_done` pulses for one cycle each period.
